floor_request_latch: RTL and testbench
======================================

FLOOR_REQUEST_LATCH -- requirements
Module: floor_request_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive high samples needed to accept a press; legal range 1..15.
REQ-002 Parameter SERVICE_TICKS, default 4: consecutive en-qualified cycles the elevator must hold one whole floor before that floor's request clears; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  tick enable; advances only the service-stability counter.
REQ-006 buttons  input  6  raw call buttons; bit k is whole floor k (k = 0..5); active-high.
REQ-007 floor  input  4  elevator position in half-floor units; even value 2k is whole floor k; odd value means between floors.
REQ-008 direction  input  1  elevator direction (1 = up); informational, feeds only last_dir.
REQ-009 floors_triggered  output  6  registered pending-request vector; bit k pending for floor k.
REQ-010 pending_count  output  3  population count of floors_triggered, 0..6.
REQ-011 busy  output  1  high when any floors_triggered bit is high.
REQ-012 last_dir  output  1  registered copy of direction, sampled when a request is cleared.

Function
REQ-013 Each button bit shall have an independent per-bit press detector that produces a one-cycle set pulse per press.
REQ-014 Set pulse k shall set floors_triggered[k]; the bit shall hold until cleared by service or reset.
REQ-015 Repeated presses at an already pending floor shall leave the bit at 1 with no other effect.
REQ-016 The stability counter shall reset to 0 on any cycle where floor differs from its registered previous value.
REQ-017 If floor is unchanged and en=1, the counter shall increment and saturate at SERVICE_TICKS.
REQ-018 If floor is unchanged and en=0, the counter shall hold.
REQ-019 Service condition: counter == SERVICE_TICKS, floor even, and floor <= 10.
REQ-020 While the service condition is true, bit floor[3:1] shall be cleared on every cycle.
REQ-021 Odd floor values or values 11..15 shall never clear any bit, while the counter still runs per REQ-016..REQ-018.
REQ-022 If a set pulse and a clear hit the same bit in one cycle, clear shall win and the bit reads 0.
REQ-023 Set and clear of different bits in the same cycle shall both take effect.
REQ-024 last_dir shall load direction on any cycle a pending bit transitions 1->0 through service, and hold otherwise.
REQ-025 pending_count and busy shall be combinational from the floors_triggered register, with no additional latency.

Reset
REQ-026 When rst=1 at a clock edge: floors_triggered=0, pending_count=0, busy=0, last_dir=1, stability counter=0, previous-floor register=0, all debounce counters=0, all edge-history bits=0.
REQ-027 Reset shall take priority over all set and clear activity in the same cycle.
REQ-028 A press in progress during reset shall be discarded and restart detection from zero afterwards.

Configuration
REQ-029 Macro FLOOR_REQUEST_DEBOUNCE_EN selects the press-detection method.
REQ-030 When FLOOR_REQUEST_DEBOUNCE_EN is defined, each button shall use a per-bit 4-bit counter:
- the counter increments while the button samples 1, saturating at DEBOUNCE_CYCLES;
- the counter resets to 0 on any sample of 0;
- the set pulse fires on the cycle the counter first reaches DEBOUNCE_CYCLES;
- the bit reads 1 after the DEBOUNCE_CYCLES-th consecutive high edge.
REQ-031 When FLOOR_REQUEST_DEBOUNCE_EN is undefined, the set pulse shall fire when the raw button is 1 and its registered previous sample is 0; the bit reads 1 after the first high edge; DEBOUNCE_CYCLES is ignored.

Verification
REQ-032 Debounce on, DEBOUNCE_CYCLES=3: buttons[2] high for 2 cycles then low -> floors_triggered stays 0; then high for 3 cycles -> floors_triggered=6'b000100 after 3rd edge, pending_count=1, busy=1.
REQ-033 Pending floors 1 and 4, floor held at 8, en=1 every cycle, SERVICE_TICKS=4 -> bit 4 clears after 4th en edge (floors_triggered=6'b000010), pending_count=1; last_dir equals direction at that edge.
REQ-034 floor held at 8 with en toggling 1,0,1,0,... -> clear of bit 4 requires 4 en-high cycles (8 clocks); floor changed to 9 mid-count -> counter restarts, no clear.
REQ-035 Elevator parked at floor 6 with service condition true, buttons[3] pressed -> bit 3 never becomes 1; press at floor 0 in same cycle -> bit 0 sets.
REQ-036 All six floors pending, then rst=1 for one cycle -> floors_triggered=0, pending_count=0, busy=0, last_dir=1 on the next cycle; a button held through reset sets only after a fresh detection window.

Source files
------------

// File: rtl/floor_request_latch.sv
// rtl/floor_request_latch.sv - latches debounced floor call buttons and clears them on stable service
// Define FLOOR_REQUEST_DEBOUNCE_EN for counter debounce; otherwise presses are rising-edge detected.
module floor_request_latch #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int SERVICE_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] buttons,
  input  logic [3:0] floor,
  input  logic       direction,
  output logic [5:0] floors_triggered,
  output logic [2:0] pending_count,
  output logic       busy,
  output logic       last_dir
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..15");
  end
  if (SERVICE_TICKS < 1 || SERVICE_TICKS > 15) begin : g_bad_service
    $error("SERVICE_TICKS must be in 1..15");
  end

  localparam logic [3:0] SVC_MAX = 4'(SERVICE_TICKS);

  logic [5:0] set_pulse;
  logic [5:0] clr_mask;
  logic [3:0] stab_cnt;
  logic [3:0] prev_floor;
  logic       service;

`ifdef FLOOR_REQUEST_DEBOUNCE_EN
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);

  logic [3:0] db_cnt [6];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rst || !buttons[k]) begin
        db_cnt[k] <= 4'd0;
      end else if (db_cnt[k] != DB_MAX) begin
        db_cnt[k] <= db_cnt[k] + 4'd1;
      end
    end
  end

  // Fires only on the sample that carries the counter into saturation.
  always_comb begin
    set_pulse = 6'd0;
    for (int k = 0; k < 6; k++) begin
      set_pulse[k] = buttons[k] && (db_cnt[k] == DB_MAX - 4'd1);
    end
  end
`else
  logic [5:0] prev_buttons;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_buttons <= 6'd0;
    end else begin
      prev_buttons <= buttons;
    end
  end

  assign set_pulse = buttons & ~prev_buttons;
`endif

  // Dwell counter: any movement restarts it, en only gates counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt   <= 4'd0;
      prev_floor <= 4'd0;
    end else begin
      prev_floor <= floor;
      if (floor != prev_floor) begin
        stab_cnt <= 4'd0;
      end else if (en && stab_cnt != SVC_MAX) begin
        stab_cnt <= stab_cnt + 4'd1;
      end
    end
  end

  assign service  = (stab_cnt == SVC_MAX) && !floor[0] && (floor <= 4'd10);
  assign clr_mask = service ? (6'b000001 << floor[3:1]) : 6'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      floors_triggered <= 6'd0;
      last_dir         <= 1'b1;
    end else begin
      floors_triggered <= (floors_triggered | set_pulse) & ~clr_mask;
      if ((floors_triggered & clr_mask) != 6'd0) begin
        last_dir <= direction;
      end
    end
  end

  always_comb begin
    pending_count = 3'd0;
    for (int k = 0; k < 6; k++) begin
      pending_count = pending_count + 3'(floors_triggered[k]);
    end
  end

  assign busy = |floors_triggered;

endmodule

// File: tb/tb_floor_request_latch.sv
// tb/tb_floor_request_latch.sv - randomized and directed check of floor_request_latch against a reference model
module tb_floor_request_latch;

  localparam int DC = 3;
  localparam int ST = 4;
`ifdef FLOOR_REQUEST_DEBOUNCE_EN
  localparam int THRESH = DC;
`else
  localparam int THRESH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [5:0] buttons = 6'd0;
  logic [3:0] floor = 4'd0;
  logic       direction = 1'b0;
  logic [5:0] floors_triggered;
  logic [2:0] pending_count;
  logic       busy;
  logic       last_dir;

  floor_request_latch #(.DEBOUNCE_CYCLES(DC), .SERVICE_TICKS(ST)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .buttons          (buttons),
    .floor            (floor),
    .direction        (direction),
    .floors_triggered (floors_triggered),
    .pending_count    (pending_count),
    .busy             (busy),
    .last_dir         (last_dir)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: per-floor pending flag, length of current high run per button,
  // and how many en-cycles the car has sat still at its current position.
  bit m_pend [6];
  int m_run  [6];
  int m_last_floor;
  int m_dwell;
  bit m_dir;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  f;
    bit  serve;
    bit  was;
    f = int'(floor);
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        m_pend[k] = 1'b0;
        m_run[k]  = 0;
      end
      m_last_floor = 0;
      m_dwell      = 0;
      m_dir        = 1'b1;
      return;
    end
    serve = (m_dwell >= ST) && (f % 2 == 0) && (f <= 10);
    for (int k = 0; k < 6; k++) begin
      m_run[k] = buttons[k] ? ((m_run[k] < 1000) ? m_run[k] + 1 : m_run[k]) : 0;
      was = m_pend[k];
      if (m_run[k] == THRESH) m_pend[k] = 1'b1;
      if (serve && k == f / 2) begin
        m_pend[k] = 1'b0;
        if (was) m_dir = direction;
      end
    end
    if (f != m_last_floor) m_dwell = 0;
    else if (en && m_dwell < ST) m_dwell++;
    m_last_floor = f;
  endtask

  function automatic int model_vec();
    int v = 0;
    for (int k = 0; k < 6; k++) v += int'(m_pend[k]) << k;
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int k = 0; k < 6; k++) c += int'(m_pend[k]);
    return c;
  endfunction

  task automatic compare_all();
    check("floors_triggered", int'(floors_triggered), model_vec());
    check("pending_count", int'(pending_count), model_count());
    check("busy", int'(busy), int'(model_count() != 0));
    check("last_dir", int'(last_dir), int'(m_dir));
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  int hold_left = 0;

  initial begin
    rst = 1'b1;
    cycle(2);
    check("reset_vec", int'(floors_triggered), 0);
    check("reset_last_dir", int'(last_dir), 1);
    check("reset_busy", int'(busy), 0);

    // Two requests latched while the car is between floors, then parked at floor 4.
    rst = 1'b0;
    floor = 4'd3;
    buttons = 6'b010010;
    cycle(4);
    check("press_1_4", int'(floors_triggered), 6'b010010);
    buttons = 6'd0;
    floor = 4'd8;
    en = 1'b1;
    direction = 1'b0;
    cycle(8);
    check("serve_floor4", int'(floors_triggered), 6'b000010);
    check("serve_count", int'(pending_count), 1);
    check("serve_dir", int'(last_dir), 0);

    // Parked and in service at floor 3: its button must never latch, floor 0 must.
    floor = 4'd6;
    cycle(6);
    buttons = 6'b001001;
    cycle(4);
    check("parked_bit3", int'(floors_triggered[3]), 0);
    check("parked_bit0", int'(floors_triggered[0]), 1);
    buttons = 6'd0;
    cycle(2);

    // Odd position never clears even with a saturated counter.
    floor = 4'd5;
    buttons = 6'b000100;
    cycle(10);
    check("odd_no_clear", int'(floors_triggered[2]), 1);

    // All floors pending, reset with buttons held, then fresh detection.
    floor = 4'd15;
    buttons = 6'b111111;
    cycle(4);
    check("all_pending", int'(floors_triggered), 63);
    rst = 1'b1;
    cycle(1);
    check("rst_vec", int'(floors_triggered), 0);
    check("rst_count", int'(pending_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dir", int'(last_dir), 1);
    rst = 1'b0;
    cycle(THRESH + 2);
    buttons = 6'd0;
    cycle(2);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (hold_left == 0) begin
        if ($urandom_range(0, 1) == 0) floor = 4'(2 * $urandom_range(0, 5));
        else floor = 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 14);
      end else begin
        hold_left--;
      end
      en = ($urandom_range(0, 9) < 7);
      direction = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 9) < 2) buttons[k] = ~buttons[k];
      end
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
